// File: rtl/upsample_pkg.sv
// Shared upsample accelerator constants, FSM state type and lane helper.
// Imported by the interfaces, the address generator and upsample_ctrl.
package upsample_pkg;

  localparam int N_PE     = 4;
  localparam int LOG_N_PE = 2;
  localparam int N_BUF    = 8;
  localparam int ADDR_RAM = 16;

  typedef enum logic [1:0] {
    IDLE,
    BLK,
    RUN,
    DRAIN
  } UpsampleStates;

  // Enable mask with the lowest n lanes set.
  function automatic logic [N_BUF-1:0] lane_mask(
    input logic [15:0] n
  );
    logic [N_BUF-1:0] m;
    m = '0;
    for (int i = 0; i < N_BUF; i++) begin
      m[i] = (16'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/upsample_if.sv
// Register-file and buffer-port interfaces of the upsample block.
// regfile: layer geometry in, output size out; buf: m1 read/write port.
interface upsample_regfile_if;
  logic [15:0] upsample__data_ch;
  logic [15:0] upsample__data_wid;
  logic [15:0] upsample__data_hei;
  logic [15:0] upsample__up_horiz;
  logic [15:0] upsample__up_vert;
  logic [15:0] upsample__out_data_wid;
  logic [15:0] upsample__out_data_hei;

  modport blk (
    input  upsample__data_ch,
    input  upsample__data_wid,
    input  upsample__data_hei,
    input  upsample__up_horiz,
    input  upsample__up_vert,
    output upsample__out_data_wid,
    output upsample__out_data_hei
  );

  modport host (
    output upsample__data_ch,
    output upsample__data_wid,
    output upsample__data_hei,
    output upsample__up_horiz,
    output upsample__up_vert,
    input  upsample__out_data_wid,
    input  upsample__out_data_hei
  );
endinterface

interface upsample_buf_if;
  import upsample_pkg::*;
  logic [N_BUF-1:0]               m1_r_en;
  logic [N_BUF-1:0][ADDR_RAM-1:0] m1_r_addr;
  logic [N_BUF-1:0]               m1_w_en;
  logic [N_BUF-1:0][ADDR_RAM-1:0] m1_w_addr;

  modport ctrl (
    output m1_r_en,
    output m1_r_addr,
    output m1_w_en,
    output m1_w_addr
  );

  modport mem (
    input m1_r_en,
    input m1_r_addr,
    input m1_w_en,
    input m1_w_addr
  );
endinterface

// File: rtl/upsample_addr_gen.sv
// Divider-free source/output index walk for nearest-neighbour upsampling.
// Ports: clk, rst, i_clr, i_adv, geometry in; o_src, o_out_idx out.
module upsample_addr_gen
  import upsample_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_adv,
  input  logic [15:0] i_wid,
  input  logic [15:0] i_up_h,
  input  logic [15:0] i_up_v,
  input  logic [15:0] i_wo,
  output logic [15:0] o_src,
  output logic [15:0] o_out_idx
);

  logic [15:0] r_hx;
  logic [15:0] r_vy;
  logic [15:0] r_sx;
  logic [15:0] r_srow;
  logic [15:0] r_ox;
  logic [15:0] r_oidx;

  assign o_src     = r_srow + r_sx;
  assign o_out_idx = r_oidx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hx   <= '0;
      r_vy   <= '0;
      r_sx   <= '0;
      r_srow <= '0;
      r_ox   <= '0;
      r_oidx <= '0;
    end else if (i_clr) begin
      r_hx   <= '0;
      r_vy   <= '0;
      r_sx   <= '0;
      r_srow <= '0;
      r_ox   <= '0;
      r_oidx <= '0;
    end else if (i_adv) begin
      r_oidx <= r_oidx + 16'd1;
      if (r_ox == i_wo - 16'd1) begin
        // end of output row: restart the source row walk
        r_ox <= '0;
        r_hx <= '0;
        r_sx <= '0;
        if (r_vy == i_up_v - 16'd1) begin
          r_vy   <= '0;
          r_srow <= r_srow + i_wid;
        end else begin
          r_vy <= r_vy + 16'd1;
        end
      end else begin
        r_ox <= r_ox + 16'd1;
        if (r_hx == i_up_h - 16'd1) begin
          r_hx <= '0;
          r_sx <= r_sx + 16'd1;
        end else begin
          r_hx <= r_hx + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/upsample_ctrl.sv
// Upsample layer controller: walks channel blocks, reads BUF2, writes BUF1.
// Ports: clk, rst, start, regfile, buf2/buf1 m1 ports, aybz_azby, done.
module upsample_ctrl
  import upsample_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  upsample_regfile_if.blk       regfile,
  upsample_buf_if.ctrl          intf_buf2_m1_ctrl,
  upsample_buf_if.ctrl          intf_buf1_m1_ctrl,
  output logic [1:0]            aybz_azby,
  output logic                  done
);

  UpsampleStates     r_state;
  logic signed [7:0] r_cb;
  logic              r_wv;
  logic [15:0]       r_waddr;
  logic [N_BUF-1:0]  r_wmask;
  logic              r_done;

  logic [15:0] w_ch, w_w, w_h, w_uh, w_uv;
  logic [15:0] w_wo, w_ho, w_in_size, w_out_size;
  logic [15:0] w_cb_n, w_extra, w_cbe, w_cb16, w_cbu;
  logic [15:0] w_src, w_oidx, w_raddr, w_waddr;
  logic        w_zero, w_last_blk, w_part, w_run, w_clr, w_final;
  logic [N_BUF-1:0] w_mask;

  assign w_ch = regfile.upsample__data_ch;
  assign w_w  = regfile.upsample__data_wid;
  assign w_h  = regfile.upsample__data_hei;
  assign w_uh = regfile.upsample__up_horiz;
  assign w_uv = regfile.upsample__up_vert;

  assign w_wo       = w_w * w_uh;
  assign w_ho       = w_h * w_uv;
  assign w_in_size  = w_w * w_h;
  assign w_out_size = w_wo * w_ho;

  assign regfile.upsample__out_data_wid = w_wo;
  assign regfile.upsample__out_data_hei = w_ho;

  assign w_cb_n  = w_ch >> LOG_N_PE;
  assign w_extra = w_ch & 16'(N_PE - 1);
  assign w_cbe   = w_cb_n + {15'd0, (w_extra != 16'd0)};
  assign w_cb16  = 16'(r_cb);
  assign w_cbu   = {8'd0, r_cb};

  assign w_zero = (w_ch == '0) || (w_w == '0) || (w_h == '0) ||
                  (w_uh == '0) || (w_uv == '0);
  assign w_last_blk = (w_cb16 == w_cbe - 16'd1);

  // trailing partial block uses only the leftover channels
  assign w_part = (w_extra != '0) && (w_cb16 == w_cb_n);
  assign w_mask = lane_mask(w_part ? w_extra : 16'(N_PE));

  assign w_run   = (r_state == RUN);
  assign w_clr   = (r_state == BLK);
  assign w_raddr = w_in_size * w_cbu + w_src;
  assign w_waddr = w_out_size * w_cbu + w_oidx;
  assign w_final = (w_oidx == w_out_size - 16'd1);

  upsample_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_adv     (w_run),
    .i_wid     (w_w),
    .i_up_h    (w_uh),
    .i_up_v    (w_uv),
    .i_wo      (w_wo),
    .o_src     (w_src),
    .o_out_idx (w_oidx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cb    <= -8'sd1;
      r_wv    <= 1'b0;
      r_waddr <= '0;
      r_wmask <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_wv    <= w_run;
      r_waddr <= w_run ? w_waddr : '0;
      r_wmask <= w_run ? w_mask : '0;
      unique case (r_state)
        IDLE: begin
          if (start) r_state <= BLK;
        end
        BLK: begin
          if (w_zero || w_last_blk) begin
            r_done  <= 1'b1;
            r_cb    <= -8'sd1;
            r_state <= IDLE;
          end else begin
            r_cb    <= r_cb + 8'sd1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_final) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state <= BLK;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign aybz_azby = 2'b10;

  always_comb begin
    intf_buf2_m1_ctrl.m1_r_en   = w_run ? w_mask : '0;
    intf_buf2_m1_ctrl.m1_w_en   = '0;
    intf_buf2_m1_ctrl.m1_r_addr = '0;
    intf_buf2_m1_ctrl.m1_w_addr = '0;
    intf_buf1_m1_ctrl.m1_r_en   = '0;
    intf_buf1_m1_ctrl.m1_w_en   = r_wv ? r_wmask : '0;
    intf_buf1_m1_ctrl.m1_r_addr = '0;
    intf_buf1_m1_ctrl.m1_w_addr = '0;
    for (int i = 0; i < N_BUF; i++) begin
      if (w_run && w_mask[i])
        intf_buf2_m1_ctrl.m1_r_addr[i] = w_raddr;
      if (r_wv && r_wmask[i])
        intf_buf1_m1_ctrl.m1_w_addr[i] = r_waddr;
    end
  end

endmodule

// File: tb/tb_upsample_ctrl.sv
// Self-checking bench for upsample_ctrl against a cycle-level reference.
// Scenario tasks drive layers and compare every output every cycle.
module tb_upsample_ctrl;
  import upsample_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] aybz;
  logic       done;

  upsample_regfile_if rf();
  upsample_buf_if     b2();
  upsample_buf_if     b1();

  upsample_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .regfile           (rf),
    .intf_buf2_m1_ctrl (b2),
    .intf_buf1_m1_ctrl (b1),
    .aybz_azby         (aybz),
    .done              (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] obs_r[$];
  logic [15:0] obs_w[$];

  // Runs one layer; extra start pulse at start_at, rst asserted after
  // sampling cycle rst_at (-1 disables either).
  task automatic test_layer(input int ch, input int w, input int h,
                            input int uh, input int uv,
                            input int start_at, input int rst_at);
    int wo, ho, ins, outs, cbn, ex, cbe, len;
    bit degen;
    logic [N_BUF-1:0] e_ren[];
    logic [N_BUF-1:0] e_wen[];
    logic [15:0]      e_ra[];
    logic [15:0]      e_wa[];
    bit               e_dn[];
    logic [N_BUF-1:0][15:0] xr, xw;
    logic [N_BUF-1:0] er, ew;
    bit xd;
    wo = w * uh; ho = h * uv; ins = w * h; outs = wo * ho;
    cbn = ch / N_PE; ex = ch % N_PE; cbe = cbn + ((ex != 0) ? 1 : 0);
    degen = (ch == 0) || (w == 0) || (h == 0) || (uh == 0) || (uv == 0);
    len = degen ? 2 : cbe * (outs + 2) + 2;
    e_ren = new[len + 4]; e_wen = new[len + 4];
    e_ra = new[len + 4];  e_wa = new[len + 4]; e_dn = new[len + 4];
    for (int i = 0; i < len + 4; i++) begin
      e_ren[i] = '0; e_wen[i] = '0; e_ra[i] = '0; e_wa[i] = '0;
      e_dn[i] = 1'b0;
    end
    if (!degen) begin
      for (int cb = 0; cb < cbe; cb++) begin
        int t0, nl, m;
        t0 = 2 + cb * (outs + 2);
        nl = (ex != 0 && cb == cbn) ? ex : N_PE;
        m = (1 << nl) - 1;
        for (int k = 0; k < outs; k++) begin
          int oy, ox, src;
          oy = k / wo; ox = k % wo;
          src = (oy / uv) * w + ox / uh;
          e_ren[t0 + k] = m[N_BUF-1:0];
          e_ra[t0 + k] = 16'(ins * cb + src);
          e_wen[t0 + k + 1] = m[N_BUF-1:0];
          e_wa[t0 + k + 1] = 16'(outs * cb + k);
        end
      end
    end
    e_dn[len] = 1'b1;

    rf.upsample__data_ch  = 16'(ch);
    rf.upsample__data_wid = 16'(w);
    rf.upsample__data_hei = 16'(h);
    rf.upsample__up_horiz = 16'(uh);
    rf.upsample__up_vert  = 16'(uv);
    obs_r.delete(); obs_w.delete();
    @(negedge clk);
    total++;
    if (rf.upsample__out_data_wid !== 16'(wo) ||
        rf.upsample__out_data_hei !== 16'(ho)) begin
      bad++;
      $display("FAIL out_size got=%0d,%0d exp=%0d,%0d",
               rf.upsample__out_data_wid, rf.upsample__out_data_hei, wo, ho);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int off = 1; off <= len + 3; off++) begin
      bit gone;
      gone = (rst_at >= 0) && (off > rst_at);
      er = gone ? '0 : e_ren[off];
      ew = gone ? '0 : e_wen[off];
      xd = gone ? 1'b0 : e_dn[off];
      for (int l = 0; l < N_BUF; l++) begin
        xr[l] = er[l] ? e_ra[off] : 16'd0;
        xw[l] = ew[l] ? e_wa[off] : 16'd0;
      end
      total += 5;
      if (b2.m1_r_en !== er || b2.m1_r_addr !== xr) begin
        bad++;
        $display("FAIL rd off=%0d got=%h/%h exp=%h/%h",
                 off, b2.m1_r_en, b2.m1_r_addr, er, xr);
      end
      if (b1.m1_w_en !== ew || b1.m1_w_addr !== xw) begin
        bad++;
        $display("FAIL wr off=%0d got=%h/%h exp=%h/%h",
                 off, b1.m1_w_en, b1.m1_w_addr, ew, xw);
      end
      if (b2.m1_w_en !== '0 || b2.m1_w_addr !== '0) begin
        bad++;
        $display("FAIL buf2_w off=%0d got=%h exp=0", off, b2.m1_w_en);
      end
      if (b1.m1_r_en !== '0 || b1.m1_r_addr !== '0) begin
        bad++;
        $display("FAIL buf1_r off=%0d got=%h exp=0", off, b1.m1_r_en);
      end
      if (done !== xd) begin
        bad++;
        $display("FAIL done off=%0d got=%b exp=%b", off, done, xd);
      end
      if (b2.m1_r_en[0]) obs_r.push_back(b2.m1_r_addr[0]);
      if (b1.m1_w_en[0]) obs_w.push_back(b1.m1_w_addr[0]);
      if (off == rst_at) rst = 1'b1;
      start = (off + 1 == start_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total += 2;
    if (b2.m1_r_en !== '0 || b2.m1_r_addr !== '0 ||
        b1.m1_w_en !== '0 || b1.m1_w_addr !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got=%h/%h/%b exp=0",
               b2.m1_r_en, b1.m1_w_en, done);
    end
    if (aybz !== 2'b10) begin
      bad++;
      $display("FAIL aybz got=%b exp=10", aybz);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] exp_src[16];
    exp_src = '{0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3};
    test_layer(N_PE, 2, 2, 2, 2, -1, -1);
    total++;
    if (obs_r.size() != 16 || obs_w.size() != 16) begin
      bad++;
      $display("FAIL basic_cnt got=%0d,%0d exp=16,16",
               obs_r.size(), obs_w.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total += 2;
        if (obs_r[i] !== exp_src[i]) begin
          bad++;
          $display("FAIL basic_src i=%0d got=%0d exp=%0d",
                   i, obs_r[i], exp_src[i]);
        end
        if (obs_w[i] !== 16'(i)) begin
          bad++;
          $display("FAIL basic_waddr i=%0d got=%0d exp=%0d", i, obs_w[i], i);
        end
      end
    end
  endtask

  task automatic test_partial_block();
    test_layer(N_PE + 3, 3, 1, 3, 1, -1, -1);
  endtask

  task automatic test_degenerate();
    test_layer(0, 2, 2, 2, 2, -1, -1);
    test_layer(N_PE, 2, 2, 0, 2, -1, -1);
  endtask

  task automatic test_midrun_reset();
    test_layer(N_PE, 2, 2, 2, 2, -1, 6);
    test_layer(N_PE, 2, 2, 2, 2, -1, -1);
  endtask

  task automatic test_copy();
    test_layer(N_PE, 4, 4, 1, 1, 5, -1);
    total++;
    if (obs_r.size() != 16 || obs_r != obs_w) begin
      bad++;
      $display("FAIL copy_addr got=%0d reads exp=16 equal to writes",
               obs_r.size());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      test_layer(int'($urandom_range(1, 10)), int'($urandom_range(1, 4)),
                 int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 3)), -1, -1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rf.upsample__data_ch  = '0;
    rf.upsample__data_wid = '0;
    rf.upsample__data_hei = '0;
    rf.upsample__up_horiz = '0;
    rf.upsample__up_vert  = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_partial_block();
    test_degenerate();
    test_midrun_reset();
    test_copy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
